// File: rtl/types_pkg.sv
// Shared types for the LSU: word/register types, the LSU state, RV32I size codes
// and helpers for legality and byte-enable generation.
package types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [3:0]  be_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; sub-word accesses must be naturally aligned.
    function automatic logic lsu_legal(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic legal;
        case (f3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~off[0];
            F3_W:    legal = (off == 2'b00);
            F3_BU:   legal = is_load;
            F3_HU:   legal = is_load & ~off[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic be_t lsu_be(input logic [1:0] size, input logic [1:0] off);
        be_t be;
        case (size)
            2'b00:   be = be_t'(4'b0001 << off);
            2'b01:   be = be_t'(4'b0011 << off);
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: moves the addressed byte/half to bit 0 and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import types_pkg::*;
(
    input  word_t      rdata,
    input  logic [1:0] offset,
    input  logic [2:0] funct3,
    output word_t      data
);

    word_t shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_wb.sv
// Load/store unit between execute and register-file writeback, driving a req/gnt/rvalid
// data memory port. Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_wb
    import types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic       ex_is_store,
    input  logic [2:0] ex_funct3,
    input  word_t      ex_addr,
    input  word_t      ex_store_data,
    input  reg_addr_t  ex_rd,
    output logic       dmem_req,
    output logic       dmem_we,
    output be_t        dmem_be,
    output word_t      dmem_addr,
    output word_t      dmem_wdata,
    input  logic       dmem_gnt,
    input  logic       dmem_rvalid,
    input  word_t      dmem_rdata,
    output logic       lsu_stall,
    output logic       lsu_wb_en,
    output reg_addr_t  lsu_wb_rd,
    output word_t      lsu_wb_data,
    output logic       lsu_fault
);

    lsu_state_t state_q, state_d;
    word_t      addr_q, addr_d;
    logic [2:0] funct3_q, funct3_d;
    reg_addr_t  rd_q, rd_d;
    logic       we_q, we_d;
    be_t        be_q, be_d;
    word_t      wdata_q, wdata_d;
    word_t      wb_data_q, wb_data_d;
    word_t      aligned;
    word_t      st_data;
    logic       accept;
    logic       timeout;

    assign accept = ex_valid & (ex_is_load | ex_is_store);

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   st_data = {4{ex_store_data[7:0]}};
            2'b01:   st_data = {2{ex_store_data[15:0]}};
            default: st_data = ex_store_data;
        endcase
    end

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Holds 0 in IDLE, so it is already clear on the first REQ cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StReq || state_q == StWait) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == StReq || state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        dmem_req  = 1'b0;
        lsu_stall = 1'b0;
        lsu_wb_en = 1'b0;
        lsu_fault = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (lsu_legal(ex_is_load, ex_funct3, ex_addr[1:0])) begin
                        addr_d    = ex_addr;
                        funct3_d  = ex_funct3;
                        rd_d      = ex_rd;
                        we_d      = ex_is_store;
                        be_d      = lsu_be(ex_funct3[1:0], ex_addr[1:0]);
                        wdata_d   = st_data;
                        lsu_stall = 1'b1;
                        state_d   = StReq;
                    end else begin
                        lsu_fault = 1'b1;
                    end
                end
            end
            StReq: begin
                if (timeout) begin
                    lsu_fault = 1'b1;
                    state_d   = StIdle;
                end else begin
                    dmem_req  = 1'b1;
                    lsu_stall = 1'b1;
                    if (dmem_gnt) state_d = we_q ? StDone : StWait;
                end
            end
            StWait: begin
                if (timeout) begin
                    lsu_fault = 1'b1;
                    state_d   = StIdle;
                end else begin
                    lsu_stall = 1'b1;
                    if (dmem_rvalid) begin
                        wb_data_d = aligned;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                lsu_wb_en = ~we_q & (rd_q != '0);
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign dmem_we     = we_q;
    assign dmem_be     = be_q;
    assign dmem_addr   = {addr_q[31:2], 2'b00};
    assign dmem_wdata  = wdata_q;
    assign lsu_wb_rd   = rd_q;
    assign lsu_wb_data = wb_data_q;

endmodule

// File: tb/tb_lsu_mem_wb.sv
// Directed bench for lsu_mem_wb; define LSU_TIMEOUT_EN to also exercise the watchdog.
module tb_lsu_mem_wb;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid, ex_is_load, ex_is_store;
    logic [2:0] ex_funct3;
    word_t      ex_addr, ex_store_data;
    reg_addr_t  ex_rd;
    logic       dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    be_t        dmem_be;
    word_t      dmem_addr, dmem_wdata, dmem_rdata;
    logic       lsu_stall, lsu_wb_en, lsu_fault;
    reg_addr_t  lsu_wb_rd;
    word_t      lsu_wb_data;

    word_t      ref_rdata, ref_data;
    logic [1:0] ref_off;
    logic [2:0] ref_f3;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    lsu_mem_wb #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .lsu_stall     (lsu_stall),
        .lsu_wb_en     (lsu_wb_en),
        .lsu_wb_rd     (lsu_wb_rd),
        .lsu_wb_data   (lsu_wb_data),
        .lsu_fault     (lsu_fault)
    );

    lsu_load_align u_ref (
        .rdata  (ref_rdata),
        .offset (ref_off),
        .funct3 (ref_f3),
        .data   (ref_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next falling edge, well away from the active edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [2:0] f3, input word_t a, input word_t d,
                           input reg_addr_t rd);
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = ~ld;
        ex_funct3     = f3;
        ex_addr       = a;
        ex_store_data = d;
        ex_rd         = rd;
        #1;
    endtask

    task automatic retire();
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input word_t a,
                            input word_t d, input be_t exp_be, input word_t exp_wdata);
        present(1'b0, f3, a, d, 5'd0);
        check({tag, " accept stall"}, lsu_stall, 1'b1);
        step();
        dmem_gnt = 1'b1;
        #1;
        check({tag, " req"}, dmem_req, 1'b1);
        check({tag, " we"}, dmem_we, 1'b1);
        check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, " be"}, dmem_be, exp_be);
        check({tag, " wdata"}, dmem_wdata, exp_wdata);
        check({tag, " req stall"}, lsu_stall, 1'b1);
        step();
        dmem_gnt = 1'b0;
        #1;
        check({tag, " done stall"}, lsu_stall, 1'b0);
        check({tag, " done wb_en"}, lsu_wb_en, 1'b0);
        retire();
        step();
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input word_t a,
                           input reg_addr_t rd, input word_t rdata, input word_t exp);
        present(1'b1, f3, a, 32'h0, rd);
        check({tag, " accept stall"}, lsu_stall, 1'b1);
        step();
        dmem_gnt = 1'b1;
        #1;
        check({tag, " req"}, dmem_req, 1'b1);
        check({tag, " we"}, dmem_we, 1'b0);
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1;
        check({tag, " wait stall"}, lsu_stall, 1'b1);
        check({tag, " wait req"}, dmem_req, 1'b0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        ref_rdata   = rdata;
        ref_off     = a[1:0];
        ref_f3      = f3;
        #1;
        check({tag, " done stall"}, lsu_stall, 1'b0);
        check({tag, " wb_en"}, lsu_wb_en, rd != 5'd0);
        check({tag, " wb_rd"}, lsu_wb_rd, rd);
        check({tag, " wb_data"}, lsu_wb_data, exp);
        check({tag, " wb_data ref"}, lsu_wb_data, ref_data);
        retire();
        step();
        check({tag, " wb_en drop"}, lsu_wb_en, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        retire();
        ex_funct3 = 3'b0; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ref_rdata = '0; ref_off = '0; ref_f3 = '0;
        step();
        step();
        check("rst req", dmem_req, 1'b0);
        check("rst stall", lsu_stall, 1'b0);
        check("rst wb_en", lsu_wb_en, 1'b0);
        check("rst wb_data", lsu_wb_data, 32'h0);
        check("rst be", dmem_be, 4'h0);
        check("rst fault", lsu_fault, 1'b0);
        rst_n = 1'b1;
        step();

        do_store("sw", F3_W, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        do_store("sb", F3_B, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
        do_store("sh", F3_H, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);

        do_load("lb",  F3_B,  32'h102, 5'd5, 32'h12807F34, 32'hFFFFFF80);
        do_load("lbu", F3_BU, 32'h102, 5'd5, 32'h12807F34, 32'h00000080);
        do_load("lh",  F3_H,  32'h102, 5'd5, 32'h12807F34, 32'h00001280);
        do_load("lh neg", F3_H, 32'h102, 5'd9, 32'h80010000, 32'hFFFF8001);
        do_load("lhu", F3_HU, 32'h100, 5'd3, 32'h1280F734, 32'h0000F734);
        do_load("lw",  F3_W,  32'h104, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D);

        // Stray handshakes while idle must not start anything.
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        #1;
        check("idle stray req", dmem_req, 1'b0);
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        check("idle stray wb_en", lsu_wb_en, 1'b0);
        check("idle stray stall", lsu_stall, 1'b0);

        present(1'b1, F3_W, 32'h101, 32'h0, 5'd4);
        check("lw mis fault", lsu_fault, 1'b1);
        check("lw mis stall", lsu_stall, 1'b0);
        check("lw mis req", dmem_req, 1'b0);
        retire();
        step();
        check("lw mis fault drop", lsu_fault, 1'b0);
        check("lw mis idle req", dmem_req, 1'b0);
        present(1'b0, F3_BU, 32'h100, 32'h0, 5'd0);
        check("sbu fault", lsu_fault, 1'b1);
        check("sbu stall", lsu_stall, 1'b0);
        retire();
        present(1'b0, F3_H, 32'h103, 32'h0, 5'd0);
        check("sh mis fault", lsu_fault, 1'b1);
        retire();
        step();

        // Slow LW to rd=0: gnt on the third REQ cycle, rvalid two cycles after gnt.
        stall_cycles = 0;
        present(1'b1, F3_W, 32'h200, 32'h0, 5'd0);
        stall_cycles += int'(lsu_stall);
        for (int i = 0; i < 3; i++) begin
            step();
            dmem_gnt = (i == 2);
            #1;
            check("slow req", dmem_req, 1'b1);
            check("slow addr", dmem_addr, 32'h200);
            check("slow be", dmem_be, 4'b1111);
            stall_cycles += int'(lsu_stall);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            dmem_gnt    = 1'b0;
            dmem_rvalid = (i == 1);
            dmem_rdata  = 32'h55AA55AA;
            #1;
            check("slow wait req", dmem_req, 1'b0);
            stall_cycles += int'(lsu_stall);
        end
        step();
        dmem_rvalid = 1'b0;
        #1;
        stall_cycles += int'(lsu_stall);
        check("slow stall cycles", stall_cycles, 6);
        check("slow wb_en rd0", lsu_wb_en, 1'b0);
        retire();
        step();

        // Reset while waiting for read data; the late response must be dropped.
        present(1'b1, F3_W, 32'h300, 32'h0, 5'd7);
        step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #1;
        check("rstw in wait stall", lsu_stall, 1'b1);
        rst_n = 1'b0;
        retire();
        step();
        check("rstw req", dmem_req, 1'b0);
        check("rstw stall", lsu_stall, 1'b0);
        check("rstw wb_en", lsu_wb_en, 1'b0);
        check("rstw addr", dmem_addr, 32'h0);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77777777;
        step();
        dmem_rvalid = 1'b0;
        #1;
        check("rstw late wb_en", lsu_wb_en, 1'b0);
        check("rstw late wb_data", lsu_wb_data, 32'h0);
        check("rstw late stall", lsu_stall, 1'b0);
        step();
        check("rstw late wb_en 2", lsu_wb_en, 1'b0);

`ifdef LSU_TIMEOUT_EN
        // gnt withheld: four REQ cycles, then the fault cycle.
        present(1'b0, F3_W, 32'h400, 32'h1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to req", dmem_req, 1'b1);
            check("to no fault", lsu_fault, 1'b0);
        end
        step();
        check("to fault", lsu_fault, 1'b1);
        check("to stall", lsu_stall, 1'b0);
        check("to req drop", dmem_req, 1'b0);
        retire();
        step();
        check("to fault pulse", lsu_fault, 1'b0);
        check("to idle req", dmem_req, 1'b0);
        check("to wb_en", lsu_wb_en, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
